// File: rtl/dct_coef_engine_if.sv
// Handshake bundle for dct_coef_engine: sample-vector request side and result side.
interface dct_coef_engine_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 19
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  x0, x1, x2, x3, x4, x5, x6, x7;
    logic [2:0]              k_sel;
    logic                    all_k;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [2:0]              out_k;
    logic                    out_last;

    modport slave (
        input  in_valid, x0, x1, x2, x3, x4, x5, x6, x7, k_sel, all_k, out_ready,
        output in_ready, out_valid, out_data, out_k, out_last
    );

    modport master (
        output in_valid, x0, x1, x2, x3, x4, x5, x6, x7, k_sel, all_k, out_ready,
        input  in_ready, out_valid, out_data, out_k, out_last
    );
endinterface

// File: rtl/dct_coef_engine.sv
// 8-point DCT-II coefficient engine: butterfly pre-add, then a 4-step MAC per
// coefficient against an internal cosine table; one Z_k or Z_0..Z_7 per vector.
module dct_coef_engine #(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 19,
    parameter int FRAC_DROP = 8
) (
    input logic            clk,
    input logic            rst,
    dct_coef_engine_if.slave bus
);
    localparam int SD_W   = IN_W + 1;
    localparam int PROD_W = IN_W + COEF_W + 1;
    localparam int ACC_W  = IN_W + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, BFLY, MAC, RND, OUT} state_t;

    state_t                  state, state_nxt;
    logic signed [IN_W-1:0]  xr [8];
    logic signed [SD_W-1:0]  s_r [4];
    logic signed [SD_W-1:0]  d_r [4];
    logic [2:0]              k_r;
    logic                    all_r;
    logic [1:0]              cnt;
    logic signed [ACC_W-1:0] acc, acc_sh;
    logic signed [SD_W-1:0]  op;
    logic signed [COEF_W-1:0] c;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0] sat_v, out_data_r;
    logic [2:0]              out_k_r;
    logic                    out_last_r;
    logic                    accept, out_fire, last_k;

    // Cosine magnitudes held at Q30 and rounded down to the table scale, so the
    // table tracks COEF_W. Angle (2n+1)k*pi/16 is folded into the first quadrant.
    function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] k, input logic [1:0] n);
        int          m;
        logic        neg;
        logic [31:0] q;
        longint      v;
        m   = ((2 * int'(n) + 1) * int'(k)) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        if (k == 3'd0) m = 4;
        case (m)
            0:       q = 32'd1073741824;
            1:       q = 32'd1053110176;
            2:       q = 32'd992008094;
            3:       q = 32'd892783698;
            4:       q = 32'd759250125;
            5:       q = 32'd596538995;
            6:       q = 32'd410903207;
            7:       q = 32'd209476638;
            default: q = 32'd0;
        endcase
        v = (longint'(q) + (longint'(1) <<< (31 - COEF_W))) >>> (32 - COEF_W);
        if (neg) v = -v;
        return COEF_W'(v);
    endfunction

    assign bus.in_ready  = (state == IDLE) & ~rst;
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_data_r;
    assign bus.out_k     = out_k_r;
    assign bus.out_last  = out_last_r;
    assign accept        = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;
    assign last_k        = ~all_r | (k_r == 3'd7);

    // Even k uses the symmetric sums, odd k the antisymmetric differences.
    always_comb begin
        op     = k_r[0] ? d_r[cnt] : s_r[cnt];
        c      = coef(k_r, cnt);
        prod   = PROD_W'(op) * PROD_W'(c);
        acc_sh = acc >>> FRAC_DROP;
        if (acc_sh > OMAX)      sat_v = {1'b0, {(OUT_W-1){1'b1}}};
        else if (acc_sh < OMIN) sat_v = {1'b1, {(OUT_W-1){1'b0}}};
        else                    sat_v = acc_sh[OUT_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BFLY;
            BFLY:    state_nxt = MAC;
            MAC:     if (cnt == 2'd3) state_nxt = RND;
            RND:     state_nxt = OUT;
            OUT:     if (out_fire) state_nxt = last_k ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) xr[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                s_r[i] <= '0;
                d_r[i] <= '0;
            end
            k_r        <= '0;
            all_r      <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            out_data_r <= '0;
            out_k_r    <= '0;
            out_last_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    xr[0] <= bus.x0; xr[1] <= bus.x1; xr[2] <= bus.x2; xr[3] <= bus.x3;
                    xr[4] <= bus.x4; xr[5] <= bus.x5; xr[6] <= bus.x6; xr[7] <= bus.x7;
                    k_r   <= bus.all_k ? 3'd0 : bus.k_sel;
                    all_r <= bus.all_k;
                end
                BFLY: begin
                    for (int i = 0; i < 4; i++) begin
                        s_r[i] <= SD_W'(xr[i]) + SD_W'(xr[7-i]);
                        d_r[i] <= SD_W'(xr[i]) - SD_W'(xr[7-i]);
                    end
                    acc <= '0;
                    cnt <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    cnt <= cnt + 2'd1;
                end
                RND: begin
                    out_data_r <= sat_v;
                    out_k_r    <= k_r;
                    out_last_r <= last_k;
                end
                OUT: if (out_fire && !last_k) begin
                    k_r <= k_r + 3'd1;
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
